indirect_calc_sched: RTL and testbench
======================================

Name: indirect_calc_sched

Overview:
- Frame-level scheduler for the indirect (feature-match) residual datapath: Idx2Cloud, then TransMat, then IndirectCoe/Proj, 12-cycle fixed latency, no stall input.
- Walks the match buffer for one frame and issues one match pair per cycle into the datapath.
- Latches the 3x4 pose for the whole frame and drops zero-depth matches.
- Flow-controls issue with a credit counter so the downstream result FIFO never overflows, since the datapath cannot stall.
- Reports done, counts and errors to the solver control FSM.

Parameters:
- MATCH_BW, 10, width of match count and buffer address (max 1023 matches).
- CREDITS, 16, depth of downstream result FIFO; initial credit value.
- DRAIN_TO, 32, max cycles in DRAIN without a datapath return before timeout error.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_start  in  1  frame start pulse; honoured only in IDLE
- i_num_match  in  MATCH_BW  matches in frame; sampled on accepted i_start
- i_pose_we  in  1  pose register write strobe
- i_pose_sel  in  4  pose element index 0..11
- i_pose_wdata  in  POSE_BW  pose element value
- o_pose_k (k=0..11)  out  POSE_BW each  latched pose to datapath
- o_rd_en  out  1  match buffer read strobe
- o_rd_addr  out  MATCH_BW  match buffer address
- i_rd_idx0_x, i_rd_idx1_x  in  H_SIZE_BW  read data; valid 1 cycle after o_rd_en
- i_rd_idx0_y, i_rd_idx1_y  in  V_SIZE_BW  read data; same timing
- i_rd_depth0  in  DATA_DEPTH_BW  read data; same timing
- o_dp_valid  out  1  datapath issue strobe
- o_dp_idx0_x, o_dp_idx1_x  out  H_SIZE_BW  registered match fields to datapath
- o_dp_idx0_y, o_dp_idx1_y  out  V_SIZE_BW  registered match fields to datapath
- o_dp_depth0  out  DATA_DEPTH_BW  registered depth to datapath
- i_dp_valid  in  1  datapath result valid
- i_res_pop  in  1  downstream FIFO pop; returns one credit
- o_busy  out  1  FSM not in IDLE
- o_done  out  1  one-cycle frame-complete pulse
- o_err  out  1  sticky error; cleared on accepted i_start
- o_issue_cnt, o_skip_cnt, o_ret_cnt  out  MATCH_BW each  frame statistics

Behaviour:
- Reset clears all outputs, counters and pose registers to 0; credit = CREDITS; FSM = IDLE. Reset mid-frame abandons the frame with no o_done.
- Pose writes are accepted only in IDLE; i_pose_sel > 11 is ignored; writes in other states are ignored.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: accepted i_start clears counters and o_err, latches N = i_num_match, and goes to RUN. If N == 0 it goes to DONE instead.
- RUN:
  - o_rd_en = 1 when credit > 0 and rd_addr < N; o_rd_addr increments by 1 per read.
  - After the last read, go to DRAIN.
- Read pipeline:
  - Read at cycle t; data sampled at t+1; o_dp_* registered and valid at t+2.
  - If i_rd_depth0 == 0: no o_dp_valid, o_skip_cnt increments, credit returned at t+1.
  - Otherwise o_dp_valid pulses and o_issue_cnt increments.
  - o_dp_* fields hold their last value when o_dp_valid = 0.
- Credit:
  - Decrement on o_rd_en; increment on i_res_pop and on skip.
  - Simultaneous events apply as net sum in one cycle.
  - Increment past CREDITS saturates at CREDITS and sets o_err.
- o_ret_cnt increments on i_dp_valid.
  - i_dp_valid while IDLE, or when o_ret_cnt == o_issue_cnt with no in-flight reads, sets o_err and is not counted.
- DRAIN:
  - Exit to DONE when no read is in flight and o_ret_cnt == o_issue_cnt.
  - Watchdog resets on every i_dp_valid. On reaching DRAIN_TO it sets o_err and forces DONE.
- DONE: o_done = 1 for exactly one cycle, then IDLE. Counters hold until the next start.
- Invariant: o_issue_cnt + o_skip_cnt == N at o_done, except on timeout.
- i_start outside IDLE is ignored.

Test Plan:
- Write pose 0..11 = 1..12, start N=3, all depths non-zero, datapath model returns 12 cycles after issue, FIFO pops immediately -> o_rd_en at start+1..+3; o_dp_valid at +3..+5; o_done once; issue=3, skip=0, ret=3, o_err=0.
- N=5, depth0=0 at addresses 1 and 3 -> o_dp_valid pulses 3 times; skip=2, issue=3, ret=3; o_done asserted.
- CREDITS=16, N=40, no i_res_pop until cycle 60 -> reads stall after 16; credit never negative; resume after pops; completes with issue=40.
- N=0 start -> o_done pulses 1 cycle after start; no o_rd_en; all counters 0.
- Datapath model drops one result, N=4 -> DRAIN times out after 32 cycles; o_err=1 with o_done; o_err clears on next start.
- Reset asserted during RUN at address 7; pose write and i_start issued during RUN -> immediate IDLE; counters 0; o_done never pulses; pose write and start during RUN have no effect.

Source files
------------

// File: rtl/indirect_calc_sched.sv
// Frame scheduler for the indirect residual datapath: walks the match
// buffer, issues non-zero-depth pairs and meters issue with FIFO credits.
module indirect_calc_sched #(
  parameter int MATCH_BW      = 10,
  parameter int CREDITS       = 16,
  parameter int DRAIN_TO      = 32,
  parameter int POSE_BW       = 24,
  parameter int H_SIZE_BW     = 11,
  parameter int V_SIZE_BW     = 10,
  parameter int DATA_DEPTH_BW = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [MATCH_BW-1:0]      i_num_match,
  input  logic                     i_pose_we,
  input  logic [3:0]               i_pose_sel,
  input  logic [POSE_BW-1:0]       i_pose_wdata,
  output logic [POSE_BW-1:0]       o_pose_0,
  output logic [POSE_BW-1:0]       o_pose_1,
  output logic [POSE_BW-1:0]       o_pose_2,
  output logic [POSE_BW-1:0]       o_pose_3,
  output logic [POSE_BW-1:0]       o_pose_4,
  output logic [POSE_BW-1:0]       o_pose_5,
  output logic [POSE_BW-1:0]       o_pose_6,
  output logic [POSE_BW-1:0]       o_pose_7,
  output logic [POSE_BW-1:0]       o_pose_8,
  output logic [POSE_BW-1:0]       o_pose_9,
  output logic [POSE_BW-1:0]       o_pose_10,
  output logic [POSE_BW-1:0]       o_pose_11,
  output logic                     o_rd_en,
  output logic [MATCH_BW-1:0]      o_rd_addr,
  input  logic [H_SIZE_BW-1:0]     i_rd_idx0_x,
  input  logic [H_SIZE_BW-1:0]     i_rd_idx1_x,
  input  logic [V_SIZE_BW-1:0]     i_rd_idx0_y,
  input  logic [V_SIZE_BW-1:0]     i_rd_idx1_y,
  input  logic [DATA_DEPTH_BW-1:0] i_rd_depth0,
  output logic                     o_dp_valid,
  output logic [H_SIZE_BW-1:0]     o_dp_idx0_x,
  output logic [H_SIZE_BW-1:0]     o_dp_idx1_x,
  output logic [V_SIZE_BW-1:0]     o_dp_idx0_y,
  output logic [V_SIZE_BW-1:0]     o_dp_idx1_y,
  output logic [DATA_DEPTH_BW-1:0] o_dp_depth0,
  input  logic                     i_dp_valid,
  input  logic                     i_res_pop,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic [MATCH_BW-1:0]      o_issue_cnt,
  output logic [MATCH_BW-1:0]      o_skip_cnt,
  output logic [MATCH_BW-1:0]      o_ret_cnt
);

  localparam int CW  = $clog2(CREDITS + 1);
  localparam int CW1 = CW + 1;
  localparam int WW  = $clog2(DRAIN_TO + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [MATCH_BW-1:0] ONE = MATCH_BW'(1);
  localparam logic [CW:0] CRED_MAX = CW1'(CREDITS);
  localparam logic [CW-1:0] CRED_RST = CW'(CREDITS);
  localparam logic [WW-1:0] WD_MAX = WW'(DRAIN_TO - 1);

  logic [1:0]          state;
  logic [MATCH_BW-1:0] num_q;
  logic [MATCH_BW-1:0] rd_addr;
  logic [CW-1:0]       credit;
  logic [CW:0]         cred_sum;
  logic [WW-1:0]       wd;
  logic                rd_vld;
  logic [POSE_BW-1:0]  pose_q [12];

  logic start_acc;
  logic rd_en;
  logic skip;
  logic issue;
  logic ret_bad;
  logic ret_ok;
  logic last_rd;
  logic drain_ok;
  logic timeout;
  logic cred_ovf;

  assign start_acc = i_start && (state == IDLE);
  assign rd_en = (state == RUN) && (credit != '0)
              && (rd_addr < num_q);
  assign skip  = rd_vld && (i_rd_depth0 == '0);
  assign issue = rd_vld && (i_rd_depth0 != '0);

  // A return with nothing outstanding is spurious and must not count.
  assign ret_bad = i_dp_valid && ((state == IDLE)
                || ((o_ret_cnt == o_issue_cnt) && !rd_vld));
  assign ret_ok  = i_dp_valid && !ret_bad;

  assign last_rd  = rd_en && ((rd_addr + ONE) == num_q);
  assign drain_ok = !rd_vld && (o_ret_cnt == o_issue_cnt);
  assign timeout  = (state == DRAIN) && !drain_ok
                 && !i_dp_valid && (wd == WD_MAX);

  assign cred_sum = {1'b0, credit} + CW1'(i_res_pop)
                  + CW1'(skip) - CW1'(rd_en);
  assign cred_ovf = cred_sum > CRED_MAX;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      num_q   <= '0;
      rd_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            num_q   <= i_num_match;
            rd_addr <= '0;
            state   <= (i_num_match == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (rd_en) rd_addr <= rd_addr + ONE;
          if (last_rd) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_ok || timeout) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd <= '0;
    end else if ((state != DRAIN) || i_dp_valid) begin
      wd <= '0;
    end else if (wd != WD_MAX) begin
      wd <= wd + WW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_vld      <= 1'b0;
      credit      <= CRED_RST;
      o_err       <= 1'b0;
      o_issue_cnt <= '0;
      o_skip_cnt  <= '0;
      o_ret_cnt   <= '0;
    end else begin
      rd_vld <= rd_en;
      credit <= cred_ovf ? CRED_RST : cred_sum[CW-1:0];
      o_err  <= (o_err && !start_acc) || ret_bad
             || cred_ovf || timeout;
      if (start_acc) begin
        o_issue_cnt <= '0;
        o_skip_cnt  <= '0;
        o_ret_cnt   <= '0;
      end else begin
        if (issue)  o_issue_cnt <= o_issue_cnt + ONE;
        if (skip)   o_skip_cnt  <= o_skip_cnt + ONE;
        if (ret_ok) o_ret_cnt   <= o_ret_cnt + ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dp_valid  <= 1'b0;
      o_dp_idx0_x <= '0;
      o_dp_idx1_x <= '0;
      o_dp_idx0_y <= '0;
      o_dp_idx1_y <= '0;
      o_dp_depth0 <= '0;
    end else begin
      o_dp_valid <= issue;
      if (issue) begin
        o_dp_idx0_x <= i_rd_idx0_x;
        o_dp_idx1_x <= i_rd_idx1_x;
        o_dp_idx0_y <= i_rd_idx0_y;
        o_dp_idx1_y <= i_rd_idx1_y;
        o_dp_depth0 <= i_rd_depth0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 12; k++) pose_q[k] <= '0;
    end else if ((state == IDLE) && i_pose_we
              && (i_pose_sel < 4'd12)) begin
      pose_q[i_pose_sel] <= i_pose_wdata;
    end
  end

  assign o_rd_en   = rd_en;
  assign o_rd_addr = rd_addr;
  assign o_busy    = state != IDLE;
  assign o_done    = state == DONE;

  assign o_pose_0  = pose_q[0];
  assign o_pose_1  = pose_q[1];
  assign o_pose_2  = pose_q[2];
  assign o_pose_3  = pose_q[3];
  assign o_pose_4  = pose_q[4];
  assign o_pose_5  = pose_q[5];
  assign o_pose_6  = pose_q[6];
  assign o_pose_7  = pose_q[7];
  assign o_pose_8  = pose_q[8];
  assign o_pose_9  = pose_q[9];
  assign o_pose_10 = pose_q[10];
  assign o_pose_11 = pose_q[11];

endmodule

// File: tb/tb_indirect_calc_sched.sv
// Scoreboard bench for indirect_calc_sched with RAM, datapath
// and result-FIFO models.
module tb_indirect_calc_sched;

  localparam int MB = 10;
  localparam int CR = 16;
  localparam int DT = 32;
  localparam int PB = 24;
  localparam int HB = 11;
  localparam int VB = 10;
  localparam int DB = 16;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_start;
  logic [MB-1:0] i_num_match;
  logic          i_pose_we;
  logic [3:0]    i_pose_sel;
  logic [PB-1:0] i_pose_wdata;
  logic [PB-1:0] o_pose [12];
  logic          o_rd_en;
  logic [MB-1:0] o_rd_addr;
  logic [HB-1:0] i_rd_idx0_x, i_rd_idx1_x;
  logic [VB-1:0] i_rd_idx0_y, i_rd_idx1_y;
  logic [DB-1:0] i_rd_depth0;
  logic          o_dp_valid;
  logic [HB-1:0] o_dp_idx0_x, o_dp_idx1_x;
  logic [VB-1:0] o_dp_idx0_y, o_dp_idx1_y;
  logic [DB-1:0] o_dp_depth0;
  logic          i_dp_valid;
  logic          i_res_pop;
  logic          o_busy, o_done, o_err;
  logic [MB-1:0] o_issue_cnt, o_skip_cnt, o_ret_cnt;

  indirect_calc_sched #(
    .MATCH_BW(MB), .CREDITS(CR), .DRAIN_TO(DT),
    .POSE_BW(PB), .H_SIZE_BW(HB), .V_SIZE_BW(VB),
    .DATA_DEPTH_BW(DB)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_start(i_start), .i_num_match(i_num_match),
    .i_pose_we(i_pose_we), .i_pose_sel(i_pose_sel),
    .i_pose_wdata(i_pose_wdata),
    .o_pose_0(o_pose[0]), .o_pose_1(o_pose[1]),
    .o_pose_2(o_pose[2]), .o_pose_3(o_pose[3]),
    .o_pose_4(o_pose[4]), .o_pose_5(o_pose[5]),
    .o_pose_6(o_pose[6]), .o_pose_7(o_pose[7]),
    .o_pose_8(o_pose[8]), .o_pose_9(o_pose[9]),
    .o_pose_10(o_pose[10]), .o_pose_11(o_pose[11]),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .i_rd_idx0_x(i_rd_idx0_x), .i_rd_idx1_x(i_rd_idx1_x),
    .i_rd_idx0_y(i_rd_idx0_y), .i_rd_idx1_y(i_rd_idx1_y),
    .i_rd_depth0(i_rd_depth0),
    .o_dp_valid(o_dp_valid),
    .o_dp_idx0_x(o_dp_idx0_x), .o_dp_idx1_x(o_dp_idx1_x),
    .o_dp_idx0_y(o_dp_idx0_y), .o_dp_idx1_y(o_dp_idx1_y),
    .o_dp_depth0(o_dp_depth0),
    .i_dp_valid(i_dp_valid), .i_res_pop(i_res_pop),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_issue_cnt(o_issue_cnt), .o_skip_cnt(o_skip_cnt),
    .o_ret_cnt(o_ret_cnt)
  );

  typedef struct packed {
    logic [HB-1:0] x0;
    logic [VB-1:0] y0;
    logic [HB-1:0] x1;
    logic [VB-1:0] y1;
    logic [DB-1:0] d;
  } pkt_t;

  typedef struct {
    int issue;
    int skip;
    int ret;
    int err;
  } frm_t;

  pkt_t exp_q[$];
  frm_t frm_q[$];
  int checks = 0;
  int passes = 0;

  logic [HB-1:0] m_x0 [1024];
  logic [HB-1:0] m_x1 [1024];
  logic [VB-1:0] m_y0 [1024];
  logic [VB-1:0] m_y1 [1024];
  logic [DB-1:0] m_d  [1024];
  logic [PB-1:0] pose_m [12];

  logic [11:0] dp_pipe;
  int dp_seen;
  int drop_idx = -1;
  int fifo_cnt;
  int fifo_max = 0;
  int pop_mode = 0;
  bit pop_coin;
  int done_cnt = 0;
  int done_base;
  pkt_t last_pkt = '0;
  pkt_t mon_e;
  frm_t mon_f;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // Synchronous match-buffer RAM: data one cycle after the read.
  always @(posedge i_clk) begin
    if (o_rd_en) begin
      i_rd_idx0_x <= m_x0[o_rd_addr];
      i_rd_idx1_x <= m_x1[o_rd_addr];
      i_rd_idx0_y <= m_y0[o_rd_addr];
      i_rd_idx1_y <= m_y1[o_rd_addr];
      i_rd_depth0 <= m_d[o_rd_addr];
    end
  end

  // Fixed 12-cycle datapath, optionally losing one result.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dp_pipe <= '0;
      dp_seen <= 0;
    end else begin
      dp_pipe <= {dp_pipe[10:0],
                  o_dp_valid && (dp_seen != drop_idx)};
      if (o_dp_valid) dp_seen <= dp_seen + 1;
    end
  end
  assign i_dp_valid = dp_pipe[11];

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_cnt <= 0;
    end else begin
      fifo_cnt <= fifo_cnt + int'(i_dp_valid) - int'(i_res_pop);
      if (fifo_cnt > fifo_max) fifo_max <= fifo_cnt;
    end
  end
  always @(posedge i_clk) pop_coin <= 1'($urandom_range(0, 1));
  assign i_res_pop = (fifo_cnt > 0) && ((pop_mode == 0)
                  || ((pop_mode == 1) && pop_coin));

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      last_pkt = '0;
    end else begin
      if (o_dp_valid) begin
        if (exp_q.size() == 0) begin
          chk("dp_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          last_pkt = {o_dp_idx0_x, o_dp_idx0_y, o_dp_idx1_x,
                      o_dp_idx1_y, o_dp_depth0};
          chk("dp_pkt", last_pkt, mon_e);
        end
      end else begin
        if (o_done) chk("dp_hold", {o_dp_idx0_x, o_dp_idx0_y,
                        o_dp_idx1_x, o_dp_idx1_y, o_dp_depth0},
                        last_pkt);
      end
      if (o_done) begin
        done_cnt++;
        if (frm_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          mon_f = frm_q.pop_front();
          chk("issue_cnt", o_issue_cnt, mon_f.issue);
          chk("skip_cnt", o_skip_cnt, mon_f.skip);
          chk("ret_cnt", o_ret_cnt, mon_f.ret);
          chk("err_at_done", o_err, mon_f.err);
          chk("dp_left", exp_q.size(), 0);
        end
      end
    end
  end

  task automatic fill_mem(input int n, input int zero_pct);
    for (int a = 0; a < n; a++) begin
      m_x0[a] = HB'($urandom);
      m_x1[a] = HB'($urandom);
      m_y0[a] = VB'($urandom);
      m_y1[a] = VB'($urandom);
      if ($urandom_range(0, 99) < zero_pct) m_d[a] = '0;
      else m_d[a] = DB'($urandom_range(1, 65535));
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    exp_q.delete();
    frm_q.delete();
    for (int k = 0; k < 12; k++) pose_m[k] = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  // Reference model: every non-zero-depth match, in buffer order.
  task automatic start_frame(input int n, input bit drop);
    frm_t f;
    int nz = 0;
    for (int a = 0; a < n; a++) begin
      if (m_d[a] != '0) begin
        exp_q.push_back({m_x0[a], m_y0[a], m_x1[a],
                         m_y1[a], m_d[a]});
        nz++;
      end
    end
    f.issue = nz;
    f.skip  = n - nz;
    f.ret   = drop ? nz - 1 : nz;
    f.err   = drop ? 1 : 0;
    frm_q.push_back(f);
    drop_idx = drop ? dp_seen + 1 : -1;
    done_base = done_cnt;
    @(posedge i_clk);
    #1;
    i_num_match = MB'(n);
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    chk("start_err_clr", o_err, 0);
    chk("start_busy", o_busy, 1);
    chk("start_cnt_clr", o_issue_cnt + o_skip_cnt + o_ret_cnt, 0);
    if (n == 0) begin
      chk("n0_done", o_done, 1);
      chk("n0_rd", o_rd_en, 0);
    end else begin
      chk("first_rd", o_rd_en, 1);
    end
  endtask

  task automatic finish_frame(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != done_base) break;
      @(posedge i_clk);
    end
    if (done_cnt == done_base) begin
      chk("done_seen", 0, 1);
      do_reset();
      return;
    end
    for (int j = 0; j < 200; j++) begin
      if (fifo_cnt == 0) break;
      @(posedge i_clk);
    end
    repeat (3) @(posedge i_clk);
    #1;
    chk("done_once", done_cnt - done_base, 1);
    chk("idle_after", o_busy, 0);
  endtask

  task automatic wr_pose(input int sel, input logic [PB-1:0] v);
    @(posedge i_clk);
    #1;
    i_pose_we = 1'b1;
    i_pose_sel = 4'(sel);
    i_pose_wdata = v;
    @(posedge i_clk);
    #1 i_pose_we = 1'b0;
    if (sel < 12) pose_m[sel] = v;
  endtask

  task automatic check_pose();
    for (int k = 0; k < 12; k++)
      chk($sformatf("pose_%0d", k), o_pose[k], pose_m[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int rd;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_num_match = '0;
    i_pose_we = 1'b0;
    i_pose_sel = '0;
    i_pose_wdata = '0;
    for (int k = 0; k < 12; k++) pose_m[k] = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rd", o_rd_en, 0);
    chk("rst_dp", o_dp_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_cnt", o_issue_cnt + o_skip_cnt + o_ret_cnt, 0);
    check_pose();
    i_rst_n = 1'b1;

    for (int k = 0; k < 12; k++) wr_pose(k, PB'(k + 1));
    wr_pose(12, 24'h0BAD01);
    wr_pose(15, 24'h0BAD02);
    check_pose();

    // N=3, full credits: reads at +1..+3, issues at +3..+5.
    fill_mem(3, 0);
    start_frame(3, 0);
    @(posedge i_clk);
    #1;
    chk("f1_rd2", o_rd_en, 1);
    chk("f1_dp2", o_dp_valid, 0);
    @(posedge i_clk);
    #1;
    chk("f1_rd3", o_rd_en, 1);
    chk("f1_dp3", o_dp_valid, 1);
    @(posedge i_clk);
    #1;
    chk("f1_rd4", o_rd_en, 0);
    finish_frame(200);
    chk("f1_err", o_err, 0);

    fill_mem(5, 0);
    m_d[1] = '0;
    m_d[3] = '0;
    start_frame(5, 0);
    finish_frame(200);

    // No pops for 60 cycles: only the 16 credits may be read.
    fill_mem(40, 0);
    pop_mode = 2;
    start_frame(40, 0);
    rd = 0;
    for (int i = 0; i < 59; i++) begin
      rd += int'(o_rd_en);
      @(posedge i_clk);
      #1;
    end
    chk("credit_stall", rd, CR);
    pop_mode = 0;
    finish_frame(1000);
    chk("fifo_peak", fifo_max, CR);

    start_frame(0, 0);
    @(posedge i_clk);
    #1;
    chk("n0_pulse_end", o_done, 0);
    finish_frame(50);

    fill_mem(4, 0);
    start_frame(4, 1);
    finish_frame(500);
    chk("err_sticky", o_err, 1);

    pop_mode = 1;
    for (int r = 0; r < 6; r++) begin
      rd = $urandom_range(1, 80);
      fill_mem(rd, 25);
      start_frame(rd, 0);
      finish_frame(3000);
    end

    // Reset mid-frame after ignored pose write and restart.
    pop_mode = 0;
    fill_mem(20, 0);
    start_frame(20, 0);
    @(posedge i_clk);
    #1;
    i_pose_we = 1'b1;
    i_pose_sel = 4'd0;
    i_pose_wdata = 24'h0ABCDE;
    i_num_match = '0;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_pose_we = 1'b0;
    i_start = 1'b0;
    chk("run_pose_ign", o_pose[0], pose_m[0]);
    chk("run_start_ign", o_busy, 1);
    for (int i = 0; i < 50; i++) begin
      if (o_rd_en && (o_rd_addr == MB'(7))) break;
      @(posedge i_clk);
      #1;
    end
    chk("addr7", o_rd_addr, 7);
    done_base = done_cnt;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_cnt", o_issue_cnt + o_skip_cnt + o_ret_cnt, 0);
    chk("mid_rst_rd", o_rd_en, 0);
    chk("mid_rst_dp", o_dp_valid, 0);
    do_reset();
    repeat (40) @(posedge i_clk);
    #1;
    chk("mid_rst_nodone", done_cnt - done_base, 0);
    chk("mid_rst_idle", o_busy, 0);
    check_pose();

    pop_mode = 1;
    fill_mem(10, 20);
    start_frame(10, 0);
    finish_frame(1000);
    chk("fifo_bound", fifo_max <= CR, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
